// File: rtl/cholesky_reconstruct.sv
// ---------------------------------------------------------------------------
// cholesky_reconstruct
//
// Rebuilds a covariance matrix A = L * L^T from a packed lower-triangular
// factor L using one sequential multiply-accumulate (one product per enabled
// clock). It is used to check a factor on chip, and to re-form covariance
// after sigma-point propagation.
//
// Packing (L and A): entry (i,j), j<=i, lives in word k = i*(i+1)/2 + j at
// bits [W*k +: W], row-major, LSB first. Entries are signed fixed point with
// FRAC fractional bits.
//
// Ports:
//   clk      in   rising-edge system clock
//   rst      in   asynchronous, active-low reset
//   clk_en   in   clock enable; all state holds while low
//   L        in   packed lower-triangular factor
//   L_valid  in   L is valid; accepted only while ready=1
//   ready    out  high while idle
//   A        out  packed reconstructed matrix; holds until the next result
//   A_valid  out  one-enabled-cycle pulse when A is updated
//   ovf      out  sticky overflow flag for the current result
//
// Build option:
//   CHOL_RECON_SAT_EN  defined   -> results outside the W-bit signed range
//                                   clamp, and ovf is set until next accept
//                      undefined -> results wrap to the low W bits, ovf = 0
// ---------------------------------------------------------------------------
module cholesky_reconstruct #(
   parameter int W    = 32,
   parameter int FRAC = 16,
   parameter int N    = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clk_en,
   input  logic [W*N*(N+1)/2-1:0]     L,
   input  logic                       L_valid,
   output logic                       ready,
   output logic [W*N*(N+1)/2-1:0]     A,
   output logic                       A_valid,
   output logic                       ovf
);

   localparam int NE = N*(N+1)/2;     // number of stored entries
   localparam int PW = 2*W;           // product width
   localparam int AW = 2*W+3;         // accumulator width
   localparam int IW = $clog2(N+1);   // row/column counter width
   localparam int KW = $clog2(NE);    // packed word index width

   typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

   state_t               state_reg, state_next;
   logic [IW-1:0]        i_reg, j_reg, m_reg;
   logic signed [AW-1:0] acc_reg;
   logic [NE*W-1:0]      a_reg;
   logic                 a_valid_reg;

   // Latched factor and per-entry result slots (no reset needed: the slots
   // are fully rewritten before they are ever copied to the port).
   logic [W-1:0]         l_reg    [NE];
   logic [W-1:0]         slot_reg [NE];
   logic [NE*W-1:0]      slot_flat;

   logic                 accept;
   logic                 last_term;
   logic                 final_term;
   logic                 slot_we;
   logic [KW-1:0]        k_im, k_jm, k_ij;
   logic signed [W-1:0]  op_a, op_b;
   logic signed [PW-1:0] prod;
   logic signed [AW-1:0] sum;
   logic signed [AW-1:0] shifted;
   logic [W-1:0]         result;
   logic                 sat;

   function automatic logic [KW-1:0] tri_idx(input logic [IW-1:0] r,
                                             input logic [IW-1:0] c);
      int ri;
      ri = int'(r);
      return KW'(ri*(ri+1)/2 + int'(c));
   endfunction

   // -------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_reg <= IDLE;
      else if (clk_en)
         state_reg <= state_next;
   end

   // FSM: next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (L_valid)    state_next = COMPUTE;
         COMPUTE: if (final_term) state_next = DONE;
         DONE:                    state_next = IDLE;
         default:                 state_next = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      ready = (state_reg == IDLE);
   end

   assign A_valid = a_valid_reg;
   assign A       = a_reg;

   // -------------------------------------------------------------------
   // MAC datapath
   // -------------------------------------------------------------------
   assign accept     = (state_reg == IDLE) && L_valid;
   assign last_term  = (m_reg == j_reg);
   assign final_term = last_term && (i_reg == IW'(N-1)) && (j_reg == IW'(N-1));
   assign slot_we    = (state_reg == COMPUTE) && last_term;

   assign k_im = tri_idx(i_reg, m_reg);
   assign k_jm = tri_idx(j_reg, m_reg);
   assign k_ij = tri_idx(i_reg, j_reg);

   assign op_a    = l_reg[k_im];
   assign op_b    = l_reg[k_jm];
   assign prod    = PW'(op_a) * PW'(op_b);
   assign sum     = acc_reg + AW'(prod);
   assign shifted = sum >>> FRAC;

`ifdef CHOL_RECON_SAT_EN
   logic [AW-W:0] hi_bits;   // sign bit of the W-bit result plus everything above

   assign hi_bits = shifted[AW-1:W-1];
   always_comb begin
      sat    = !((&hi_bits) || (~|hi_bits));
      result = shifted[W-1:0];
      if (sat)
         result = shifted[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
   end
`else
   // Wrapping build: bits above the result width are intentionally dropped.
   logic unused_hi;

   assign unused_hi = ^shifted[AW-1:W];
   assign sat       = 1'b0;
   assign result    = shifted[W-1:0];
`endif

   // Counters, accumulator, output register and valid pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         i_reg       <= '0;
         j_reg       <= '0;
         m_reg       <= '0;
         acc_reg     <= '0;
         a_reg       <= '0;
         a_valid_reg <= 1'b0;
      end else if (clk_en) begin
         a_valid_reg <= (state_reg == DONE);
         case (state_reg)
            IDLE: begin
               if (L_valid) begin
                  i_reg   <= '0;
                  j_reg   <= '0;
                  m_reg   <= '0;
                  acc_reg <= '0;
               end
            end
            COMPUTE: begin
               if (last_term) begin
                  // Entry finished: its result goes to the slot this edge,
                  // so the accumulator starts clean for the next entry.
                  acc_reg <= '0;
                  m_reg   <= '0;
                  if (j_reg == i_reg) begin
                     j_reg <= '0;
                     i_reg <= i_reg + IW'(1);
                  end else begin
                     j_reg <= j_reg + IW'(1);
                  end
               end else begin
                  acc_reg <= sum;
                  m_reg   <= m_reg + IW'(1);
               end
            end
            DONE: a_reg <= slot_flat;
            default: ;
         endcase
      end
   end

   // Factor latch and result slots.
   always_ff @(posedge clk) begin
      if (clk_en) begin
         if (accept) begin
            for (int k = 0; k < NE; k++)
               l_reg[k] <= L[W*k +: W];
         end
         if (slot_we)
            slot_reg[k_ij] <= result;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NE; gi++) begin : g_pack
         assign slot_flat[W*gi +: W] = slot_reg[gi];
      end
   endgenerate

`ifdef CHOL_RECON_SAT_EN
   logic ovf_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         ovf_reg <= 1'b0;
      else if (clk_en) begin
         if (accept)
            ovf_reg <= 1'b0;
         else if (slot_we && sat)
            ovf_reg <= 1'b1;
      end
   end

   assign ovf = ovf_reg;
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_cholesky_reconstruct.sv
// ---------------------------------------------------------------------------
// tb_cholesky_reconstruct
//
// Directed vectors with hand-computed expected matrices. The driver pushes
// the expected A, ovf and delivery cycle into a scoreboard queue when it
// issues a factor; an independent monitor pops and compares on every
// A_valid pulse.
// ---------------------------------------------------------------------------
module tb_cholesky_reconstruct;

   localparam int W  = 32;
   localparam int N  = 5;
   localparam int NE = 15;
   localparam int BW = W*NE;

   logic          clk = 1'b0;
   logic          rst;
   logic          clk_en;
   logic [BW-1:0] L;
   logic          L_valid;
   logic          ready;
   logic [BW-1:0] A;
   logic          A_valid;
   logic          ovf;

   cholesky_reconstruct #(.W(W), .FRAC(16), .N(N)) dut (
      .clk     (clk),
      .rst     (rst),
      .clk_en  (clk_en),
      .L       (L),
      .L_valid (L_valid),
      .ready   (ready),
      .A       (A),
      .A_valid (A_valid),
      .ovf     (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [BW-1:0] a;
      logic          ovf;
      int            due;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   passes = 0;
   int   cyc    = 0;
   int   txn    = 0;
   logic av_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [BW-1:0] act,
                        input logic [BW-1:0] req);
      checks++;
      if (act === req)
         passes++;
      else
         $display("FAIL %s: got %h required %h", name, act, req);
   endtask

   // Monitor: one comparison set per A_valid pulse.
   always @(negedge clk) begin
      if (A_valid && !av_prev) begin
         txn++;
         if (sb_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_A_valid: got A_valid=1 at cycle %0d, required no pulse", cyc);
         end else begin
            mon_e = sb_q.pop_front();
            $display("txn %0d: A_valid at cycle %0d, A[95:0]=%h ovf=%b", txn, cyc, A[95:0], ovf);
            check("A", A, mon_e.a);
            check("ovf", BW'(ovf), BW'(mon_e.ovf));
            check("latency", BW'(cyc), BW'(mon_e.due));
         end
      end
      av_prev <= A_valid;
   end

   function automatic logic [BW-1:0] put(input logic [BW-1:0] v, input int k,
                                         input logic [W-1:0] w);
      logic [BW-1:0] r;
      r = v;
      r[W*k +: W] = w;
      return r;
   endfunction

   // Issue one factor from an idle DUT; pushes the expectation when asked.
   task automatic send(input logic [BW-1:0] l_in, input logic [BW-1:0] a_exp,
                       input logic ovf_exp, input int stall, input bit push);
      @(negedge clk);
      check("ready_before_accept", BW'(ready), BW'(1'b1));
      L       = l_in;
      L_valid = 1'b1;
      @(negedge clk);
      L_valid = 1'b0;
      if (push) sb_q.push_back('{a_exp, ovf_exp, cyc + 36 + stall});
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         checks++;
         $display("FAIL %s_timeout: got %0d results outstanding, required 0", name, sb_q.size());
         sb_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   logic [BW-1:0] l_diag, a_diag, l_ones, a_ones, l_neg, a_neg, l_big, a_big;
   logic          ovf_big;
   int            ones_tab[NE] = '{1, 1, 2, 1, 2, 3, 1, 2, 3, 4, 1, 2, 3, 4, 5};
   int            diag_k[5]    = '{0, 2, 5, 9, 14};
   int            rdy_cnt;
   int            e0;

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Vectors
      l_diag = '0; a_diag = '0;
      for (int d = 0; d < 5; d++) begin
         l_diag = put(l_diag, diag_k[d], 32'h0005_0000);
         a_diag = put(a_diag, diag_k[d], 32'h0019_0000);
      end
      l_ones = '0; a_ones = '0;
      for (int k = 0; k < NE; k++) begin
         l_ones = put(l_ones, k, 32'h0001_0000);
         a_ones = put(a_ones, k, 32'(ones_tab[k]) << 16);
      end
      l_neg = '0;
      l_neg = put(l_neg, 0, 32'h0001_0000);
      l_neg = put(l_neg, 1, 32'hFFFE_0000);
      l_neg = put(l_neg, 2, 32'h0001_0000);
      a_neg = '0;
      a_neg = put(a_neg, 0, 32'h0001_0000);
      a_neg = put(a_neg, 1, 32'hFFFE_0000);
      a_neg = put(a_neg, 2, 32'h0005_0000);
      l_big = put('0, 0, 32'h7FFF_0000);
`ifdef CHOL_RECON_SAT_EN
      a_big   = put('0, 0, 32'h7FFF_FFFF);
      ovf_big = 1'b1;
`else
      a_big   = put('0, 0, 32'h0001_0000);
      ovf_big = 1'b0;
`endif

      // Reset state
      rst = 1'b0; clk_en = 1'b1; L_valid = 1'b0; L = '0;
      repeat (3) @(negedge clk);
      check("reset_A", A, '0);
      check("reset_A_valid", BW'(A_valid), '0);
      check("reset_ready", BW'(ready), BW'(1'b1));
      check("reset_ovf", BW'(ovf), '0);
      rst = 1'b1;

      // Basic results
      send(l_diag, a_diag, 1'b0, 0, 1'b1);
      wait_done("diag5");
      send(l_ones, a_ones, 1'b0, 0, 1'b1);
      wait_done("ones");
      send(l_neg, a_neg, 1'b0, 0, 1'b1);
      wait_done("neg");
      send(l_big, a_big, ovf_big, 0, 1'b1);
      wait_done("overflow");

      // Second L_valid at cycle 10 of COMPUTE is ignored; L also changes.
      send(l_diag, a_diag, 1'b0, 0, 1'b1);
      repeat (9) @(negedge clk);
      L = l_ones;
      L_valid = 1'b1;
      @(negedge clk);
      L_valid = 1'b0;
      rdy_cnt = (ready == 1'b1) ? 1 : 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (ready) rdy_cnt++;
      end
      check("ready_low_in_compute", BW'(rdy_cnt), '0);
      wait_done("ignored_pulse");

      // clk_en low for 10 cycles mid-COMPUTE
      send(l_neg, a_neg, 1'b0, 10, 1'b1);
      repeat (15) @(negedge clk);
      clk_en = 1'b0;
      repeat (10) @(negedge clk);
      clk_en = 1'b1;
      wait_done("stall");

      // L_valid held high: back-to-back accepts 37 cycles apart
      @(negedge clk);
      check("ready_before_b2b", BW'(ready), BW'(1'b1));
      L = l_ones;
      L_valid = 1'b1;
      @(negedge clk);
      e0 = cyc;
      sb_q.push_back('{a_ones, 1'b0, e0 + 36});
      sb_q.push_back('{a_ones, 1'b0, e0 + 73});
      repeat (37) @(negedge clk);
      L_valid = 1'b0;
      wait_done("back_to_back");

      // Reset mid-COMPUTE aborts without a result
      send(l_diag, a_diag, 1'b0, 0, 1'b0);
      repeat (15) @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_A", A, '0);
      check("abort_A_valid", BW'(A_valid), '0);
      check("abort_ready", BW'(ready), BW'(1'b1));
      @(negedge clk);
      rst = 1'b1;
      repeat (45) @(negedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
